// File: rtl/shift_engine_pkg.sv
// Shared definitions for the multi-cycle barrel-shift engine:
// shift-type encodings and the control FSM state type.
package shift_engine_pkg;

   // stype encodings
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-cycle shifter: shifts data by k (0..STEP) positions
// in the requested direction and reports the last bit shifted out.
// For ROR the reported bit is the new MSB, which is what the carry becomes.
module shift_step
   import shift_engine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       stype,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] result,
   output logic             last_out
);

   logic        [WIDTH:0]   ext_l;
   logic        [WIDTH:0]   ext_r;
   logic signed [WIDTH:0]   ext_a;
   logic        [WIDTH-1:0] rot;

   // One extra guard bit on each side catches the last bit shifted out
   always_comb begin
      ext_l    = {1'b0, data} << k;
      ext_r    = {data, 1'b0} >> k;
      ext_a    = $signed({data, 1'b0}) >>> k;
      rot      = WIDTH'({data, data} >> k);
      result   = data;
      last_out = 1'b0;
      case (stype)
         SH_LSL: begin
            result   = ext_l[WIDTH-1:0];
            last_out = ext_l[WIDTH];
         end
         SH_LSR: begin
            result   = ext_r[WIDTH:1];
            last_out = ext_r[0];
         end
         SH_ASR: begin
            result   = ext_a[WIDTH:1];
            last_out = ext_a[0];
         end
         default: begin
            result   = rot;
            last_out = rot[WIDTH-1];
         end
      endcase
   end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shift engine: captures an operand and shift request on start,
// shifts up to STEP positions per cycle, then presents Rd and NZC flags with
// a one-cycle done pulse.
// Build option: define SHIFT_ENGINE_ROR_EN to implement rotate-right;
// otherwise stype ROR passes Rm through with the captured flags unchanged.
module shift_engine
   import shift_engine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             S,
   input  logic [1:0]       stype,
   input  logic [WIDTH-1:0] Rm,
   input  logic [7:0]       operand2,
   input  logic             carry_in,
   input  logic             zero_in,
   input  logic             neg_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Rd,
   output logic             carry_out,
   output logic             zero_out,
   output logic             neg_out
);

   localparam int KW = $clog2(STEP + 1);

   state_t           state_reg, state_next;

   logic [WIDTH-1:0] data_reg;
   logic [1:0]       stype_reg;
   logic             s_reg;
   logic             cin_reg, zin_reg, nin_reg;
   logic             carry_reg;
   logic [7:0]       rem_reg;
   logic             amt_nz_reg;
   logic             over_reg;
   logic             bypass_reg;

   logic [WIDTH-1:0] rd_reg;
   logic             cout_reg, zout_reg, nout_reg;

   logic [7:0]       eff_amt;
   logic             bypass;
   logic [7:0]       step_amt;
   logic [KW-1:0]    k_step;
   logic [WIDTH-1:0] step_data;
   logic             step_last;
   logic             final_carry;

   // Effective shift count from the raw request (only meaningful when start is sampled)
   always_comb begin
      eff_amt = operand2;
      bypass  = 1'b0;
      if (stype == SH_ROR) begin
`ifdef SHIFT_ENGINE_ROR_EN
         eff_amt = operand2 & 8'(WIDTH - 1);
`else
         eff_amt = 8'd0;
         bypass  = 1'b1;
`endif
      end else if (operand2 > 8'(WIDTH)) begin
         eff_amt = 8'(WIDTH);
      end
   end

   // Per-cycle step is min(STEP, remaining); rem_reg never exceeds WIDTH
   always_comb begin
      step_amt = (rem_reg > 8'(STEP)) ? 8'(STEP) : rem_reg;
      k_step   = KW'(step_amt);
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .data     (data_reg),
      .stype    (stype_reg),
      .k        (k_step),
      .result   (step_data),
      .last_out (step_last)
   );

   // Carry resolution: ROR takes the result MSB, oversize LSL/LSR clear it,
   // everything else keeps the last bit shifted out (or carry_in if none)
   always_comb begin
      final_carry = carry_reg;
      if ((stype_reg == SH_ROR) && amt_nz_reg) begin
         final_carry = data_reg[WIDTH-1];
      end else if (over_reg) begin
         final_carry = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state: a start outside IDLE is simply dropped
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (rem_reg == 8'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on start, then one shift step per SHIFT cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg   <= '0;
         stype_reg  <= SH_LSL;
         s_reg      <= 1'b0;
         cin_reg    <= 1'b0;
         zin_reg    <= 1'b0;
         nin_reg    <= 1'b0;
         carry_reg  <= 1'b0;
         rem_reg    <= 8'd0;
         amt_nz_reg <= 1'b0;
         over_reg   <= 1'b0;
         bypass_reg <= 1'b0;
      end else begin
         if ((state_reg == IDLE) && start) begin
            data_reg   <= Rm;
            stype_reg  <= stype;
            s_reg      <= S;
            cin_reg    <= carry_in;
            zin_reg    <= zero_in;
            nin_reg    <= neg_in;
            carry_reg  <= carry_in;
            rem_reg    <= eff_amt;
            amt_nz_reg <= (operand2 != 8'd0);
            over_reg   <= ((stype == SH_LSL) || (stype == SH_LSR)) && (operand2 > 8'(WIDTH));
            bypass_reg <= bypass;
         end else if ((state_reg == SHIFT) && (rem_reg != 8'd0)) begin
            data_reg  <= step_data;
            rem_reg   <= rem_reg - step_amt;
            carry_reg <= step_last;
         end
      end
   end

   // Result and flag registers, loaded only on entry to DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_reg   <= '0;
         cout_reg <= 1'b0;
         zout_reg <= 1'b0;
         nout_reg <= 1'b0;
      end else if ((state_reg == SHIFT) && (rem_reg == 8'd0)) begin
         rd_reg <= data_reg;
         if (s_reg && !bypass_reg) begin
            cout_reg <= final_carry;
            zout_reg <= (data_reg == '0);
            nout_reg <= data_reg[WIDTH-1];
         end else begin
            cout_reg <= cin_reg;
            zout_reg <= zin_reg;
            nout_reg <= nin_reg;
         end
      end
   end

   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign Rd        = rd_reg;
   assign carry_out = cout_reg;
   assign zero_out  = zout_reg;
   assign neg_out   = nout_reg;

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine: two instances (STEP=1 and STEP=4) share
// stimulus; each transaction checks result, flags, latency and done count.
module tb_shift_engine;
   import shift_engine_pkg::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             S = 1'b0;
   logic [1:0]       stype = 2'b00;
   logic [WIDTH-1:0] Rm = '0;
   logic [7:0]       operand2 = 8'd0;
   logic             carry_in = 1'b0, zero_in = 1'b0, neg_in = 1'b0;

   logic             busy1, done1, c1, z1, n1;
   logic [WIDTH-1:0] rd1;
   logic             busy4, done4, c4, z4, n4;
   logic [WIDTH-1:0] rd4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   shift_engine #(.WIDTH(WIDTH), .STEP(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start), .S(S), .stype(stype), .Rm(Rm),
      .operand2(operand2), .carry_in(carry_in), .zero_in(zero_in), .neg_in(neg_in),
      .busy(busy1), .done(done1), .Rd(rd1), .carry_out(c1), .zero_out(z1), .neg_out(n1)
   );

   shift_engine #(.WIDTH(WIDTH), .STEP(4)) u_s4 (
      .clk(clk), .rst(rst), .start(start), .S(S), .stype(stype), .Rm(Rm),
      .operand2(operand2), .carry_in(carry_in), .zero_in(zero_in), .neg_in(neg_in),
      .busy(busy4), .done(done4), .Rd(rd4), .carry_out(c4), .zero_out(z4), .neg_out(n4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge.
   task automatic run_op(input string name, input logic [1:0] st, input logic [7:0] amt,
                         input logic [31:0] rm, input logic s, input logic ci,
                         input logic zi, input logic ni, input logic [31:0] exp_rd,
                         input logic ec, input logic ez, input logic en,
                         input int eff, input bit poke);
      int lat1 = 0, lat4 = 0, nd1 = 0, nd4 = 0;
      int exp_lat1, exp_lat4;
      logic [31:0] r1 = '0, r4 = '0;
      logic [2:0]  f1 = '0, f4 = '0;
      exp_lat1 = 1 + eff;
      exp_lat4 = 1 + (eff + 3) / 4;
      stype = st; operand2 = amt; Rm = rm; S = s;
      carry_in = ci; zero_in = zi; neg_in = ni;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "/busy1"}, busy1, 1'b1);
      check({name, "/busy4"}, busy4, 1'b1);
      // Scramble inputs: captured values must not follow them
      stype = ~st; operand2 = ~amt; Rm = ~rm; S = ~s;
      carry_in = ~ci; zero_in = ~zi; neg_in = ~ni;
      for (int i = 1; i <= 100; i++) begin
         start = poke && (i == 2);
         @(negedge clk);
         if (done1) begin
            nd1++;
            if (lat1 == 0) begin lat1 = i; r1 = rd1; f1 = {c1, z1, n1}; end
         end
         if (done4) begin
            nd4++;
            if (lat4 == 0) begin lat4 = i; r4 = rd4; f4 = {c4, z4, n4}; end
         end
         if (lat1 != 0 && lat4 != 0) break;
      end
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done1) nd1++;
         if (done4) nd4++;
      end
      check({name, "/lat1"}, lat1, exp_lat1);
      check({name, "/lat4"}, lat4, exp_lat4);
      check({name, "/rd1"}, r1, exp_rd);
      check({name, "/rd4"}, r4, exp_rd);
      check({name, "/czn1"}, f1, {ec, ez, en});
      check({name, "/czn4"}, f4, {ec, ez, en});
      check({name, "/ndone1"}, nd1, 1);
      check({name, "/ndone4"}, nd4, 1);
      check({name, "/hold1"}, rd1, exp_rd);
      check({name, "/idle"}, {busy1, busy4}, 2'b00);
      $display("op %-10s rd=%08h czn=%b%b%b lat1=%0d lat4=%0d", name, r1, f1[2], f1[1], f1[0], lat1, lat4);
   endtask

   initial begin
      int nd;
      #1 rst = 1'b0;
      #2;
      check("reset1", {busy1, done1, c1, z1, n1, rd1}, '0);
      check("reset4", {busy4, done4, c4, z4, n4, rd4}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;   // first start lands on the first edge after release

      //      name        stype   amt     Rm            S  ci zi ni  exp Rd        C  Z  N  eff poke
      run_op("lsl1",      SH_LSL, 8'd1,   32'h80000001, 1, 0, 0, 0, 32'h00000002, 1, 0, 0, 1,  0);
      run_op("asr40",     SH_ASR, 8'd40,  32'h80000000, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 32, 1);
      run_op("lsr32",     SH_LSR, 8'd32,  32'hFFFFFFFF, 1, 0, 0, 0, 32'h00000000, 1, 1, 0, 32, 0);
      run_op("lsr33",     SH_LSR, 8'd33,  32'hFFFFFFFF, 1, 1, 0, 0, 32'h00000000, 0, 1, 0, 32, 0);
      run_op("lsl0",      SH_LSL, 8'd0,   32'h12345678, 1, 1, 0, 0, 32'h12345678, 1, 0, 0, 0,  0);
      run_op("s0_lsl4",   SH_LSL, 8'd4,   32'h0000000F, 0, 1, 1, 0, 32'h000000F0, 1, 1, 0, 4,  0);
      run_op("lsl32",     SH_LSL, 8'd32,  32'h80000001, 1, 0, 0, 0, 32'h00000000, 1, 1, 0, 32, 0);
      run_op("lsr5",      SH_LSR, 8'd5,   32'hF0000010, 1, 0, 0, 0, 32'h07800000, 1, 0, 0, 5,  0);
      run_op("asr255",    SH_ASR, 8'd255, 32'h7FFFFFFF, 1, 1, 0, 1, 32'h00000000, 0, 1, 0, 32, 0);
`ifdef SHIFT_ENGINE_ROR_EN
      run_op("ror1",      SH_ROR, 8'd1,   32'h00000001, 1, 0, 0, 0, 32'h80000000, 1, 0, 1, 1,  0);
      run_op("ror64",     SH_ROR, 8'd64,  32'h00000001, 1, 1, 0, 0, 32'h00000001, 0, 0, 0, 0,  0);
      run_op("ror36",     SH_ROR, 8'd36,  32'h12345678, 1, 0, 0, 0, 32'h81234567, 1, 0, 1, 4,  0);
      run_op("ror0",      SH_ROR, 8'd0,   32'h12345678, 1, 1, 0, 0, 32'h12345678, 1, 0, 0, 0,  0);
`else
      run_op("ror_off1",  SH_ROR, 8'd1,   32'h00000001, 1, 0, 1, 1, 32'h00000001, 0, 1, 1, 0,  0);
      run_op("ror_off5",  SH_ROR, 8'd5,   32'h00000000, 1, 1, 0, 0, 32'h00000000, 1, 0, 0, 0,  0);
`endif
      run_op("asr4",      SH_ASR, 8'd4,   32'h80000010, 1, 0, 0, 0, 32'hF8000001, 0, 0, 1, 4,  0);

      // Reset in the middle of an LSL by 20: everything clears at once
      stype = SH_LSL; operand2 = 8'd20; Rm = 32'h00000001; S = 1'b1;
      carry_in = 1'b0; zero_in = 1'b0; neg_in = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst1", {busy1, done1, c1, z1, n1, rd1}, '0);
      check("midrst4", {busy4, done4, c4, z4, n4, rd4}, '0);
      @(negedge clk);
      rst = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done1 || done4) nd++;
      end
      check("midrst/nodone", nd, 0);
      $display("op %-10s reset mid-shift, done pulses after release=%0d", "rst_lsl20", nd);

      run_op("lsl20",     SH_LSL, 8'd20,  32'h00000001, 1, 0, 0, 0, 32'h00100000, 0, 0, 0, 20, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
